// File: rtl/cpu_mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-beat byte memory.
// One transaction in flight at a time, with ack-wait timeout and a saturating abort counter.
module cpu_mem_arbiter #(
  parameter int ADDRLEN = 20,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req0,
  input  logic               we0,
  input  logic [ADDRLEN-1:0] addr0,
  input  logic [7:0]         wdata0,
  output logic               done0,
  output logic               err0,
  output logic [7:0]         rdata0,
  input  logic               req1,
  input  logic               we1,
  input  logic [ADDRLEN-1:0] addr1,
  input  logic [7:0]         wdata1,
  output logic               done1,
  output logic               err1,
  output logic [7:0]         rdata1,
  output logic               mem_req,
  output logic               mem_we,
  output logic [ADDRLEN-1:0] mem_addr,
  output logic [7:0]         mem_wdata,
  input  logic               mem_ack,
  input  logic [7:0]         mem_rdata,
  output logic               busy,
  output logic               owner,
  output logic [7:0]         timeouts
);

  // Wait counter only ever holds 0..TIMEOUT-1, the abort fires on its last value.
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state, next_state;
  logic            last_served;
  logic [CW-1:0]   wait_cnt;
  logic            grant;
  logic            grant_port;
  logic            complete;
  logic            abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    next_state = state;
    grant      = 1'b0;
    grant_port = 1'b0;
    complete   = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          grant      = 1'b1;
          grant_port = (req0 && req1) ? ~last_served : req1;
          next_state = BUSY;
        end
      end
      BUSY: begin
        // An ack landing on the final wait cycle beats the abort.
        if (mem_ack) begin
          complete   = 1'b1;
          next_state = IDLE;
        end else if (wait_cnt == WAIT_LAST) begin
          complete   = 1'b1;
          abort      = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= 8'h00;
      done0       <= 1'b0;
      done1       <= 1'b0;
      err0        <= 1'b0;
      err1        <= 1'b0;
      rdata0      <= 8'h00;
      rdata1      <= 8'h00;
      owner       <= 1'b0;
      last_served <= 1'b1;
      timeouts    <= 8'h00;
      wait_cnt    <= '0;
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
      err0  <= 1'b0;
      err1  <= 1'b0;

      if (grant) begin
        owner     <= grant_port;
        mem_req   <= 1'b1;
        mem_we    <= grant_port ? we1    : we0;
        mem_addr  <= grant_port ? addr1  : addr0;
        mem_wdata <= grant_port ? wdata1 : wdata0;
        wait_cnt  <= '0;
      end

      if (state == BUSY && !complete) wait_cnt <= wait_cnt + CW'(1);

      if (complete) begin
        mem_req     <= 1'b0;
        last_served <= owner;
        if (owner) done1 <= 1'b1;
        else       done0 <= 1'b1;
        if (abort) begin
          if (owner) err1 <= 1'b1;
          else       err0 <= 1'b1;
          if (timeouts != 8'hFF) timeouts <= timeouts + 8'd1;
          if (!mem_we) begin
            if (owner) rdata1 <= 8'hFF;
            else       rdata0 <= 8'hFF;
          end
        end else if (!mem_we) begin
          if (owner) rdata1 <= mem_rdata;
          else       rdata0 <= mem_rdata;
        end
      end
    end
  end

  assign busy = (state == BUSY);

endmodule
